// File: rtl/tff_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : tff_counter_if
//  Description : Control and status bundle for tff_counter: enable, mode,
//                toggle mask and load value in; stage state, complement,
//                terminal count and wrap pulse out.
//  Revision    : 1.0  initial release
// ============================================================================
interface tff_counter_if #(
  parameter int WIDTH = 4
) ();
  logic             En;
  logic [1:0]       Mode;
  logic [WIDTH-1:0] T;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] QN;
  logic             TC;
  logic             Wrap;

  // Controller side: drives the request, observes the counter
  modport master (output En, Mode, T, D, input Q, QN, TC, Wrap);
  // Counter side
  modport slave  (input En, Mode, T, D, output Q, QN, TC, Wrap);
endinterface
`default_nettype wire

// File: rtl/tff_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tff_counter
//  Description : Bank of WIDTH toggle flip-flops. Mode 00 toggles stages
//                from a mask, 01/10 count up/down modulo MODULUS by deriving
//                per-stage toggle enables, 11 loads a clamped value.
//                Define TFF_COUNTER_SATURATE_EN to make counting saturate at
//                the terminal state instead of wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
module tff_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 2**WIDTH
) (
  input  wire             Clk,
  input  wire             Clr,
  tff_counter_if.slave    bus
);

  localparam logic [1:0]       c_MODE_MASK = 2'b00;
  localparam logic [1:0]       c_MODE_UP   = 2'b01;
  localparam logic [1:0]       c_MODE_DOWN = 2'b10;
  localparam logic [1:0]       c_MODE_LOAD = 2'b11;
  localparam logic [WIDTH-1:0] c_MAX       = WIDTH'(MODULUS - 1);
  localparam int               c_MAX_INT   = MODULUS - 1;

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic [WIDTH-1:0] w_up_tog;
  logic [WIDTH-1:0] w_dn_tog;
  logic [WIDTH-1:0] w_tog;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_q_next;
  logic             w_oor;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_tc;

  // Out-of-range only happens after mask toggling; counting modes recover to 0
  assign w_oor      = (32'(r_q) > c_MAX_INT);
  assign w_at_max   = (r_q == c_MAX);
  assign w_at_zero  = (r_q == '0);
  assign w_load_val = (32'(bus.D) < MODULUS) ? bus.D : c_MAX;

  // Ripple toggle enables: a stage flips when every lower stage is 1 (up) or 0 (down)
  always_comb begin
    logic all_ones;
    logic all_zeros;
    w_up_tog  = '0;
    w_dn_tog  = '0;
    all_ones  = 1'b1;
    all_zeros = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_up_tog[i] = all_ones;
      w_dn_tog[i] = all_zeros;
      all_ones    = all_ones & r_q[i];
      all_zeros   = all_zeros & ~r_q[i];
    end
  end

  // Per-mode toggle vector; every mode is expressed as Q ^ toggle
  always_comb begin
    w_tog = '0;
    case (bus.Mode)
      c_MODE_MASK: w_tog = bus.T;
      c_MODE_UP: begin
        if (w_oor) begin
          w_tog = r_q;
        end else if (w_at_max) begin
`ifdef TFF_COUNTER_SATURATE_EN
          w_tog = '0;
`else
          w_tog = r_q;
`endif
        end else begin
          w_tog = w_up_tog;
        end
      end
      c_MODE_DOWN: begin
        if (w_oor) begin
          w_tog = r_q;
        end else if (w_at_zero) begin
`ifdef TFF_COUNTER_SATURATE_EN
          w_tog = '0;
`else
          w_tog = c_MAX;
`endif
        end else begin
          w_tog = w_dn_tog;
        end
      end
      c_MODE_LOAD: w_tog = r_q ^ w_load_val;
      default:     w_tog = '0;
    endcase
  end

  assign w_q_next = r_q ^ w_tog;

  // Terminal count depends only on the current state and the mode in force
  assign w_tc = ((bus.Mode == c_MODE_UP)   && w_at_max) ||
                ((bus.Mode == c_MODE_DOWN) && w_at_zero);

  // Stage state and wrap pulse; clear wins over everything, disabled edges hold Q
  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else if (bus.En) begin
      r_q    <= w_q_next;
      r_wrap <= w_tc;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign bus.Q    = r_q;
  assign bus.QN   = ~r_q;
  assign bus.TC   = w_tc;
  assign bus.Wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_tff_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tff_counter
//  Description : Directed and randomized bench for tff_counter (WIDTH=4,
//                MODULUS=10) against an arithmetic reference model.
//                Follows TFF_COUNTER_SATURATE_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tff_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic Clk;
  logic Clr;

  tff_counter_if #(.WIDTH(W)) bus ();

  tff_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  int vectors;
  int miscompares;
  int mq;
  bit mwrap;

  // Free-running clock, 10 time units per cycle
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Hard stop in case anything stalls
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic bit tc_of(input logic [1:0] mode, input int q);
    return (mode == 2'b01 && q == M - 1) || (mode == 2'b10 && q == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic [1:0] mode);
    chk("Q",    32'(bus.Q),    32'(mq));
    chk("QN",   32'(bus.QN),   32'((~mq) & ((1 << W) - 1)));
    chk("TC",   32'(bus.TC),   32'(tc_of(mode, mq)));
    chk("Wrap", 32'(bus.Wrap), 32'(mwrap));
  endtask

  // Apply one edge of stimulus, advance the model, then check 1 unit past the edge
  task automatic apply(input bit clr_i, input bit en_i, input logic [1:0] mode_i,
                       input logic [W-1:0] t_i, input logic [W-1:0] d_i);
    bit tc;
    Clr      = clr_i;
    bus.En   = en_i;
    bus.Mode = mode_i;
    bus.T    = t_i;
    bus.D    = d_i;
    @(posedge Clk);
    tc = tc_of(mode_i, mq);
    if (clr_i) begin
      mq = 0; mwrap = 0;
    end else if (!en_i) begin
      mwrap = 0;
    end else begin
      mwrap = tc;
      case (mode_i)
        2'b00: mq = mq ^ int'(t_i);
        2'b01: begin
          if (mq >= M)          mq = 0;
          else if (mq == M - 1) begin
`ifdef TFF_COUNTER_SATURATE_EN
            mq = M - 1;
`else
            mq = 0;
`endif
          end else              mq = mq + 1;
        end
        2'b10: begin
          if (mq >= M)          mq = 0;
          else if (mq == 0) begin
`ifdef TFF_COUNTER_SATURATE_EN
            mq = 0;
`else
            mq = M - 1;
`endif
          end else              mq = mq - 1;
        end
        default: mq = (int'(d_i) < M) ? int'(d_i) : M - 1;
      endcase
    end
    #1;
    check_all(mode_i);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mq          = 0;
    mwrap       = 0;
    Clr         = 1'b0;
    bus.En      = 1'b0;
    bus.Mode    = 2'b00;
    bus.T       = '0;
    bus.D       = '0;
    @(negedge Clk);

    // Reset, then mask toggling 0101 twice
    apply(1, 0, 2'b00, 4'h0, 4'h0);
    apply(0, 1, 2'b00, 4'b0101, 4'h0);
    apply(0, 1, 2'b00, 4'b0101, 4'h0);

    // Count up through the modulus: TC at 9, wrap pulse on the 10th edge
    for (int i = 0; i < 11; i++) apply(0, 1, 2'b01, 4'h0, 4'h0);

    // Count down from 0
    apply(1, 0, 2'b10, 4'h0, 4'h0);
    apply(0, 1, 2'b10, 4'h0, 4'h0);
    apply(0, 1, 2'b10, 4'h0, 4'h0);

    // Load with clamp and in-range value
    apply(0, 1, 2'b11, 4'h0, 4'hC);
    apply(0, 1, 2'b11, 4'h0, 4'h3);

    // Clear while counting at 6, then hold while disabled
    apply(0, 1, 2'b11, 4'h0, 4'h6);
    apply(1, 1, 2'b01, 4'h0, 4'h0);
    for (int i = 0; i < 3; i++) apply(0, 0, 2'b01, 4'h0, 4'h0);
    apply(0, 1, 2'b01, 4'h0, 4'h0);

    // Clear pulsed between edges has no effect
    apply(0, 1, 2'b11, 4'h0, 4'h7);
    Clr = 1'b1;
    #2;
    Clr = 1'b0;
    #1;
    apply(0, 0, 2'b00, 4'h0, 4'h0);

    // Out-of-range recovery: mask to F, then count up and down recover to 0 without wrap
    apply(1, 0, 2'b00, 4'h0, 4'h0);
    apply(0, 1, 2'b00, 4'hF, 4'h0);
    apply(0, 1, 2'b01, 4'h0, 4'h0);
    apply(0, 1, 2'b00, 4'hC, 4'h0);
    apply(0, 1, 2'b10, 4'h0, 4'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 19) == 0),
            ($urandom_range(0, 4) != 0),
            2'($urandom_range(0, 3)),
            4'($urandom),
            4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tff_counter.md
TFF_COUNTER -- requirements
Module: tff_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: number of toggle stages, legal range 2..16.
REQ-002 SHALL have parameter MODULUS, default 2**WIDTH: count modulus, legal range 2..2**WIDTH.
REQ-003 SHALL have port Clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port Clr, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port En, input, 1 bit: global enable; when low, state holds.
REQ-006 SHALL have port Mode, input, 2 bits: 00 toggle-mask, 01 count up, 10 count down, 11 load.
REQ-007 SHALL have port T, input, WIDTH bits: per-stage toggle mask, used in mode 00 only.
REQ-008 SHALL have port D, input, WIDTH bits: load value, used in mode 11 only.
REQ-009 SHALL have port Q, output, WIDTH bits: registered stage state.
REQ-010 SHALL have port QN, output, WIDTH bits: bitwise complement of Q, combinational.
REQ-011 SHALL have port TC, output, 1 bit: terminal count, combinational from Q and Mode.
REQ-012 SHALL have port Wrap, output, 1 bit: registered one-cycle pulse marking a count wrap or saturation hit.

Function
REQ-013 SHALL keep Q and clear Wrap on any edge where En=0 and Clr=0.
REQ-014 SHALL, in mode 00 with En=1, set Q[i] <= ~Q[i] where T[i]=1 and hold Q[i] where T[i]=0 (independent T-FF bank).
REQ-015 SHALL, in mode 01 with En=1, set Q <= Q+1, and set Q <= 0 when Q = MODULUS-1.
REQ-016 SHALL, in mode 10 with En=1, set Q <= Q-1, and set Q <= MODULUS-1 when Q = 0.
REQ-017 SHALL, in mode 11 with En=1, set Q <= D when D < MODULUS, otherwise Q <= MODULUS-1 (clamp).
REQ-018 SHALL build counting from toggle enables: stage i toggles when all lower stages are 1 (up) or all 0 (down); the result SHALL be arithmetically identical to REQ-015/016.
REQ-019 SHALL drive TC=1 when Mode=01 and Q=MODULUS-1, or when Mode=10 and Q=0, and TC=0 in modes 00 and 11.
REQ-020 SHALL set Wrap <= 1 on an edge where En=1 and TC=1, and Wrap <= 0 otherwise; latency is one cycle after the terminal state is counted through.
REQ-021 SHALL compute the mode-00 next state from T without reference to MODULUS; Q MAY reach values ≥ MODULUS only in mode 00.
REQ-022 SHALL, in modes 01/10, load Q <= 0 on the next enabled edge when Q ≥ MODULUS (recovery from out-of-range), with no Wrap pulse.
REQ-023 SHALL apply a Mode change on the same edge on which it is sampled, with no pipeline delay.

Reset
REQ-024 SHALL set Q <= 0 and Wrap <= 0 on any rising Clk edge with Clr=1, with priority over En, Mode, T and D.
REQ-025 SHALL drive QN = all ones and TC according to REQ-019 with Q=0 while in reset.
REQ-026 SHALL NOT clear Q asynchronously; an assertion of Clr between edges has no effect until the next edge.
REQ-027 SHALL treat Clr asserted mid-count as an immediate restart: the next enabled count after release starts from 0.

Configuration
REQ-028 SHALL honour the macro TFF_COUNTER_SATURATE_EN.
REQ-029 SHALL, with TFF_COUNTER_SATURATE_EN defined, hold Q at MODULUS-1 (up) or 0 (down) instead of wrapping, still pulsing Wrap on each enabled edge at the terminal state.
REQ-030 SHALL, without TFF_COUNTER_SATURATE_EN, wrap per REQ-015/016; port list and mode 00/11 behaviour SHALL be identical in both builds.

Verification
REQ-031 SHALL cover this scenario: WIDTH=4, Clr=1 for 1 edge, then Mode=00, T=4'b0101, En=1 for 2 edges -> Q=0101 then 0000; QN=1010 then 1111.
REQ-032 SHALL cover this scenario: MODULUS=10, Mode=01, En=1 for 10 edges from 0 -> Q=9 with TC=1 after 9 edges, Q=0 after 10 edges, Wrap=1 for exactly that cycle.
REQ-033 SHALL cover this scenario: MODULUS=10, Mode=10 from Q=0, 1 edge -> Q=9, Wrap=1; in the saturate build -> Q=0, Wrap=1.
REQ-034 SHALL cover this scenario: Mode=11, D=4'hC, MODULUS=10 -> Q=9; D=4'h3 -> Q=3.
REQ-035 SHALL cover this scenario: counting up at Q=6, Clr=1 and En=1 on the same edge -> Q=0, Wrap=0; En=0 for 3 edges -> Q holds.
REQ-036 SHALL cover this scenario: Mode=00 drives Q=4'hF with MODULUS=10, then Mode=01 for 1 edge -> Q=0 with Wrap=0.
